data_mem_slave: RTL and testbench

- Memory-side responder for the core's data-memory port, replacing the zero-latency combinational RAM path with a valid/ready request/response interface.
- The core (initiator) issues one load/store request at a time; this block accepts it, inserts LATENCY wait states, performs the access on an internal word array and returns a response.
- Enables the multi-cycle core to be tested against realistic memory timing and back-pressure.

---
 rtl/data_mem_slave.sv | 139 +++++++++++++
 tb/tb_data_mem_slave.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_slave.sv
// Data-memory responder: valid/ready load/store slave over an internal word array.
// Latency: response valid LATENCY+2 cycles after the request cycle (accept edge N, rsp_valid after edge N+1+LATENCY).
// Backpressure: one outstanding request; response held stable until rsp_ready, req_ready low while busy.
`timescale 1ns/1ps
module data_mem_slave #(
  parameter int    AW        = 32,
  parameter int    DW        = 32,
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_wstrb,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err
);

  localparam int SW    = DW / 8;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Word storage; contents survive reset.
  logic [DW-1:0] mem_q [DEPTH];

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic [DW-1:0]      rsp_rdata_q;
  logic               rsp_err_q;

  // Request captured at acceptance; never follows the live inputs afterwards.
  logic               we_q;
  logic [AW-1:0]      addr_q;
  logic [DW-1:0]      wdata_q;
  logic [SW-1:0]      wstrb_q;

  logic [AW-3:0]      word_idx;
  logic [IW-1:0]      mem_idx;
  logic               acc_err;
  logic               acc_edge;
  logic               mem_we;

  // Decode the captured address and decide whether this edge is the access edge.
  always_comb begin
    word_idx = addr_q[AW-1:2];
    mem_idx  = word_idx[IW-1:0];
    acc_err  = (addr_q[1:0] != 2'b00) || (word_idx >= (AW-2)'(DEPTH));
    acc_edge = (state_q == S_WAIT) && (cnt_q == '0);
    mem_we   = acc_edge && we_q && !acc_err;
  end

  // Byte-lane store into the array at the access edge; zero strobe writes nothing.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < SW; i++) begin
        if (wstrb_q[i]) begin
          mem_q[mem_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            wstrb_q     <= req_wstrb;
            cnt_q       <= CNT_W'(LATENCY);
            req_ready_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // Stores and errors return zero data; loads return the whole word.
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= acc_err;
            rsp_rdata_q <= (acc_err || we_q) ? '0 : mem_q[mem_idx];
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_slave.sv
// Bench for data_mem_slave: LATENCY=2 instance for function/backpressure/errors/reset,
// LATENCY=0 instance for back-to-back throughput with rsp_ready tied high.
// Expected responses are queued at request time and compared when the DUT responds.
`timescale 1ns/1ps
module tb_data_mem_slave;

  logic        clk;
  logic        rst;

  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [3:0]  b_req_wstrb;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  int n_chk = 0;
  int n_err = 0;

  logic [32:0] sb_q [$];

  data_mem_slave #(.AW(32), .DW(32), .DEPTH(1024), .LATENCY(2), .INIT_FILE("")) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_slave #(.AW(32), .DW(32), .DEPTH(1024), .LATENCY(0), .INIT_FILE("")) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one request, wait for acceptance, optionally queue its expected response.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] exp_d, input logic exp_e,
                       input bit track);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    if (track) sb_q.push_back({exp_e, exp_d});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'(~strb);
  endtask

  // Wait for the response, hold it off for 'hold' cycles, compare against the queue.
  task automatic finish_rsp(input int hold);
    int n;
    logic [31:0] d0;
    logic        e0;
    logic [32:0] exp;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rsp_latency", n, 3);
    d0 = rsp_rdata;
    e0 = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", rsp_valid, 1);
      check("hold_rdata", rsp_rdata, d0);
      check("hold_err", rsp_err, e0);
      check("hold_req_ready", req_ready, 0);
    end
    if (sb_q.size() == 0) begin
      check("sb_nonempty", 0, 1);
      exp = '0;
    end else begin
      exp = sb_q.pop_front();
    end
    check("rsp_rdata", rsp_rdata, exp[31:0]);
    check("rsp_err", rsp_err, exp[32]);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_cleared", {rsp_valid, rsp_err, rsp_rdata}, 0);
    check("req_ready_after", req_ready, 1);
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic [31:0] exp_d, input logic exp_e,
                     input int hold);
    issue(we, addr, wdata, strb, exp_d, exp_e, 1'b1);
    finish_rsp(hold);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } item_t;

  initial begin
    item_t       items [5];
    logic [31:0] model [int];
    logic [32:0] bexp [$];
    int          bacc [$];
    logic [32:0] e;
    int          t;
    int          idx, cyc, last_acc, nresp, seen;
    bit          acc_pend;

    rst         = 1'b0;
    req_valid   = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready   = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_wstrb = '0;
    b_rsp_ready = 1'b1;

    #3;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Basic store then load.
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
    // Byte strobes.
    txn(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 0);
    txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 0);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 0);
    // Zero strobe is a no-op.
    txn(1'b1, 32'h10, 32'h01234567, 4'h0, 32'h0, 1'b0, 0);
    // Back-pressure on a load.
    txn(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 5);
    // Errors: misaligned load, out-of-range store leaves last word intact.
    txn(1'b0, 32'h3, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    txn(1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 0);
    txn(1'b1, 32'h1000, 32'h0BADBAD0, 4'hF, 32'h0, 1'b1, 0);
    txn(1'b0, 32'hFFC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 0);
    txn(1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0, 1'b1, 2);
    txn(1'b1, 32'h102, 32'h5, 4'hF, 32'h0, 1'b1, 0);

    // Reset during WAIT of a store: abandoned, no response, no write.
    txn(1'b1, 32'h40, 32'h55AA55AA, 4'hF, 32'h0, 1'b0, 0);
    issue(1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_req_ready", req_ready, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_rdata", rsp_rdata, 0);
    check("midrst_rsp_err", rsp_err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    check("midrst_no_rsp", seen, 0);
    txn(1'b0, 32'h40, 32'h0, 4'h0, 32'h55AA55AA, 1'b0, 0);

    // LATENCY=0 instance: back-to-back with rsp_ready tied high.
    items[0] = '{1'b1, 32'h100, 32'hA5A50001};
    items[1] = '{1'b1, 32'h104, 32'h0BEEF002};
    items[2] = '{1'b0, 32'h100, 32'h0};
    items[3] = '{1'b0, 32'h104, 32'h0};
    items[4] = '{1'b0, 32'h100, 32'h0};
    idx = 0; cyc = 0; last_acc = -1; nresp = 0; acc_pend = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (acc_pend) begin
        idx++;
        acc_pend = 1'b0;
      end
      if (idx < 5) begin
        b_req_valid = 1'b1;
        b_req_we    = items[idx].we;
        b_req_addr  = items[idx].a;
        b_req_wdata = items[idx].d;
        b_req_wstrb = 4'hF;
      end else begin
        b_req_valid = 1'b0;
      end
      if (b_rsp_valid) begin
        if (bexp.size() == 0) begin
          check("b_sb_nonempty", 0, 1);
        end else begin
          e = bexp.pop_front();
          t = bacc.pop_front();
          check("b_rsp_rdata", b_rsp_rdata, e[31:0]);
          check("b_rsp_err", b_rsp_err, e[32]);
          check("b_rsp_lat", cyc - t, 2);
        end
        nresp++;
      end
      if (b_req_valid && b_req_ready) begin
        acc_pend = 1'b1;
        if (last_acc >= 0) check("b_acc_gap", cyc - last_acc, 3);
        last_acc = cyc;
        bacc.push_back(cyc);
        if (items[idx].we) begin
          model[int'(items[idx].a)] = items[idx].d;
          bexp.push_back({1'b0, 32'h0});
        end else begin
          bexp.push_back({1'b0, model.exists(int'(items[idx].a)) ? model[int'(items[idx].a)] : 32'h0});
        end
      end
      cyc++;
    end
    check("b_rsp_count", nresp, 5);
    check("sb_drained", sb_q.size() + bexp.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
